obstacle_field: RTL and testbench
=================================

# obstacle_field

Parametrised manager for the N falling obstacles of the game screen. It holds every obstacle's position and advances one obstacle per clock in a short sweep after each `frame` pulse. Obstacles that leave the bottom edge respawn at the top, and obstacles that leave the right edge wrap to the left. It also accumulates per-obstacle ship collisions over each frame and publishes a frame-latched hit mask plus a saturating hit counter. It sits between the VGA timing generator and the obstacle sprite instances, replacing the fixed-count, position-offset obstacle logic in the top level.

## Interface
- `N_OBST`, 10: number of obstacles (1..32).
- `CORDW`, 16: screen coordinate width.
- `H_RES`, 640: visible width.
- `V_RES`, 480: visible height.
- `SPACING_X`, 50: reset x pitch; `(N_OBST-1)*SPACING_X < H_RES` required.
- `SPACING_Y`, 30: reset y pitch; `(N_OBST-1)*SPACING_Y < V_RES` required.
- `STEP_X`, 1: x advance per frame (< H_RES).
- `STEP_Y`, 3: y advance per frame (< V_RES).
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.

- `clk_pix`  in  1  pixel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  obstacles enabled (switch).
- `frame`  in  1  one-cycle start-of-frame pulse.
- `de`  in  1  visible-region flag.
- `ship_drawing`  in  1  ship sprite covers the current pixel.
- `obst_drawing`  in  N_OBST  per-obstacle sprite covers the current pixel.
- `obst_x`  out  N_OBST×CORDW  obstacle x positions.
- `obst_y`  out  N_OBST×CORDW  obstacle y positions.
- `busy`  out  1  update sweep in progress.
- `hit_mask`  out  N_OBST  obstacles hit during the last completed frame.
- `collision`  out  1  OR of `hit_mask`.
- `hit_count`  out  8  saturating count of collision onsets.

## Operation
Reset values:
- `obst_x[i] = i*SPACING_X`, `obst_y[i] = i*SPACING_Y`.
- `busy`, `hit_mask`, `collision`, `hit_count` all 0.
- LFSR = `LFSR_SEED`.

Update FSM (states IDLE, SWEEP):
- IDLE → SWEEP on `frame && en`; index `idx` is set to 0.
- In SWEEP, each clock updates obstacle `idx`, then increments `idx`.
- SWEEP → IDLE after `idx == N_OBST-1` is updated.
- A `frame` pulse during SWEEP is ignored.
- `busy` is high exactly in SWEEP.

Per-obstacle update:
- Arithmetic is done in CORDW+1 bits: `ny = y + STEP_Y`, `nx = x + STEP_X`.
- If `ny >= V_RES`: set y = 0 and x = the respawn value.
- Otherwise: set y = ny, and x = `nx >= H_RES ? nx - H_RES : nx`.

Collision accumulator (per obstacle):
- `acc[i]` ORs in `en && de && ship_drawing && obst_drawing[i]` on every clock.
- On `frame`:
  - `hit_mask <= acc | current-cycle hits`.
  - `acc <= 0`.
  - `collision <= |(acc | current-cycle hits)`.
- `hit_count` increments on `frame` when the new `collision` is 1 and the previous one was 0; it saturates at 255.

`en` low:
- Positions hold.
- Accumulation is suppressed.
- A sweep already running completes.

## Timing
- The update for obstacle i is visible in `obst_x/y` on clock edge i+2 after the `frame` cycle. The sweep completes N_OBST+1 cycles after `frame`, which is well inside vertical blanking.
- `hit_mask`, `collision` and `hit_count` update one clock after the `frame` cycle and stay stable for the whole frame.
- LFSR (x^16+x^14+x^13+x^11+1) advances on every clock regardless of state.
- Reset asserted mid-sweep returns the block immediately to IDLE with reset values.

## Configuration
Macro `OBSTACLE_FIELD_RAND_RESPAWN_EN`:
- Defined: respawn x is taken from `r`, the low `$clog2(H_RES)` bits of the LFSR: x = `r >= H_RES ? r - H_RES : r`.
- Undefined: respawn x = `idx*SPACING_X`, which is deterministic. The LFSR is not instantiated.

## Structure
- Package `obstacle_pkg`:
  - `sweep_state_t` enum {IDLE, SWEEP}.
  - LFSR tap constant.
  - Default resolution and spacing localparams.
- Sub-module `lfsr16` (clock, reset, seed parameter, 16-bit state output), instantiated only under the macro.

## Test plan
- **Reset positions:** reset release with defaults → `obst_x[3]=150`, `obst_y[3]=90`; all outputs 0; `busy=0`.
- **Single frame update:** one `frame` with `en=1` → `busy` high for 10 cycles; then `obst_x[0]=1`, `obst_y[0]=3`, `obst_y[9]=273`.
- **Bottom respawn:** obstacle 9 at y=477 before `frame` → y=0 afterwards. x=450 with the macro undefined; x < 640 with it defined.
- **Right-edge wrap:** `STEP_X=5`, obstacle at x=638, y=0 → x=3 after one `frame`.
- **Collision latch:** overlap on obstacle 2 for 1 cycle with `de=1` mid-frame → after the next `frame`, `hit_mask=10'b0000000100`, `collision=1`, `hit_count=1`. The next overlapping frame leaves `hit_count` at 1; a clean frame followed by a hit frame gives 2.
- **Disable and mid-sweep reset:** `en=0` with overlaps and `frame` → positions unchanged and `hit_mask=0`. `reset_n` low at sweep cycle 4 → reset values and `busy=0` immediately.

Source files
------------

// File: rtl/obstacle_field_pkg.sv
// Shared types and defaults for the obstacle field manager.
package obstacle_pkg;

    typedef enum logic {
        IDLE,
        SWEEP
    } sweep_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, as a mask over state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_N_OBST    = 10;
    localparam int DEF_CORDW     = 16;
    localparam int DEF_H_RES     = 640;
    localparam int DEF_V_RES     = 480;
    localparam int DEF_SPACING_X = 50;
    localparam int DEF_SPACING_Y = 30;

endpackage

// File: rtl/obstacle_field_lfsr.sv
// 16-bit Fibonacci LFSR that free-runs on every pixel clock.
module lfsr16
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_pix,
    input  logic        reset_n,
    output logic [15:0] state
);

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEED;
        end else begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/obstacle_field.sv
// Manager for N falling obstacles: per-frame position sweep plus frame-latched collisions.
// Define OBSTACLE_FIELD_RAND_RESPAWN_EN to respawn obstacles at an LFSR-chosen x.
module obstacle_field
    import obstacle_pkg::*;
#(
    parameter int          N_OBST    = DEF_N_OBST,
    parameter int          CORDW     = DEF_CORDW,
    parameter int          H_RES     = DEF_H_RES,
    parameter int          V_RES     = DEF_V_RES,
    parameter int          SPACING_X = DEF_SPACING_X,
    parameter int          SPACING_Y = DEF_SPACING_Y,
    parameter int          STEP_X    = 1,
    parameter int          STEP_Y    = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    clk_pix,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    frame,
    input  logic                    de,
    input  logic                    ship_drawing,
    input  logic [N_OBST-1:0]       obst_drawing,
    output logic [N_OBST*CORDW-1:0] obst_x,
    output logic [N_OBST*CORDW-1:0] obst_y,
    output logic                    busy,
    output logic [N_OBST-1:0]       hit_mask,
    output logic                    collision,
    output logic [7:0]              hit_count
);

    localparam int IDXW = (N_OBST > 1) ? $clog2(N_OBST) : 1;
    localparam int CW1  = CORDW + 1;

    if ((N_OBST < 1) || (N_OBST > 32) || ((N_OBST - 1) * SPACING_X >= H_RES) ||
        ((N_OBST - 1) * SPACING_Y >= V_RES) || (STEP_X >= H_RES) ||
        (STEP_Y >= V_RES) || (LFSR_SEED == 16'h0000)) begin : g_bad_params
        $error("obstacle_field: illegal parameter combination");
    end

    sweep_state_t      state, state_n;
    logic [IDXW-1:0]   idx, idx_n;
    logic [CORDW-1:0]  pos_x [N_OBST];
    logic [CORDW-1:0]  pos_y [N_OBST];
    logic [CW1-1:0]    nx, ny, nx_wrap;
    logic [CORDW-1:0]  new_x, new_y, spawn_x;
    logic [N_OBST-1:0] acc, hits, frame_hits;

`ifdef OBSTACLE_FIELD_RAND_RESPAWN_EN
    localparam int RW = $clog2(H_RES);

    logic [15:0]    lfsr_state;
    logic [CW1-1:0] rnd;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_pix (clk_pix),
        .reset_n (reset_n),
        .state   (lfsr_state)
    );

    // Fold the raw value back into the visible width with a single subtraction.
    always_comb begin
        rnd     = CW1'(lfsr_state[RW-1:0]);
        spawn_x = (rnd >= CW1'(H_RES)) ? CORDW'(rnd - CW1'(H_RES)) : CORDW'(rnd);
    end
`else
    always_comb begin
        spawn_x = CORDW'(int'(idx) * SPACING_X);
    end
`endif

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (frame && en) begin
                    state_n = SWEEP;
                    idx_n   = '0;
                end
            end
            SWEEP: begin
                if (idx == IDXW'(N_OBST - 1)) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + IDXW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    assign busy = (state == SWEEP);

    // One extra bit of headroom so the edge tests cannot overflow.
    always_comb begin
        nx      = CW1'(pos_x[idx]) + CW1'(STEP_X);
        ny      = CW1'(pos_y[idx]) + CW1'(STEP_Y);
        nx_wrap = nx - CW1'(H_RES);
        if (ny >= CW1'(V_RES)) begin
            new_y = '0;
            new_x = spawn_x;
        end else begin
            new_y = CORDW'(ny);
            new_x = (nx >= CW1'(H_RES)) ? CORDW'(nx_wrap) : CORDW'(nx);
        end
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_OBST; i++) begin
                pos_x[i] <= CORDW'(i * SPACING_X);
                pos_y[i] <= CORDW'(i * SPACING_Y);
            end
        end else if (state == SWEEP) begin
            pos_x[idx] <= new_x;
            pos_y[idx] <= new_y;
        end
    end

    for (genvar g = 0; g < N_OBST; g++) begin : g_flatten
        assign obst_x[g*CORDW +: CORDW] = pos_x[g];
        assign obst_y[g*CORDW +: CORDW] = pos_y[g];
    end

    assign hits       = {N_OBST{en && de && ship_drawing}} & obst_drawing;
    assign frame_hits = acc | hits;

    // Hits landing in the frame cycle itself still belong to the frame being closed.
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            hit_mask  <= '0;
            collision <= 1'b0;
            hit_count <= '0;
        end else if (frame) begin
            acc       <= '0;
            hit_mask  <= frame_hits;
            collision <= |frame_hits;
            if ((|frame_hits) && !collision && (hit_count != 8'hFF)) begin
                hit_count <= hit_count + 8'd1;
            end
        end else begin
            acc <= frame_hits;
        end
    end

endmodule

// File: tb/tb_obstacle_field.sv
// Scoreboard bench for obstacle_field: stimulus queues expectations, a monitor checks them.
module tb_obstacle_field;

    localparam int N  = 10;
    localparam int CW = 16;

    logic              clk_pix = 1'b0;
    logic              reset_n;
    logic              en;
    logic              frame;
    logic              de;
    logic              ship_drawing;
    logic [N-1:0]      obst_drawing;
    logic [N*CW-1:0]   obst_x;
    logic [N*CW-1:0]   obst_y;
    logic              busy;
    logic [N-1:0]      hit_mask;
    logic              collision;
    logic [7:0]        hit_count;

    logic [2*CW-1:0]   obst_x2;
    logic [2*CW-1:0]   obst_y2;
    logic              busy2;
    logic [1:0]        hit_mask2;
    logic              collision2;
    logic [7:0]        hit_count2;

    always #5 clk_pix = ~clk_pix;

    obstacle_field dut (
        .clk_pix      (clk_pix),
        .reset_n      (reset_n),
        .en           (en),
        .frame        (frame),
        .de           (de),
        .ship_drawing (ship_drawing),
        .obst_drawing (obst_drawing),
        .obst_x       (obst_x),
        .obst_y       (obst_y),
        .busy         (busy),
        .hit_mask     (hit_mask),
        .collision    (collision),
        .hit_count    (hit_count)
    );

    // Second field sized so obstacle 1 starts at x=638, y=0 for the right-edge wrap.
    obstacle_field #(
        .N_OBST    (2),
        .SPACING_X (638),
        .SPACING_Y (0),
        .STEP_X    (5)
    ) dut_wrap (
        .clk_pix      (clk_pix),
        .reset_n      (reset_n),
        .en           (en),
        .frame        (frame),
        .de           (de),
        .ship_drawing (ship_drawing),
        .obst_drawing (obst_drawing[1:0]),
        .obst_x       (obst_x2),
        .obst_y       (obst_y2),
        .busy         (busy2),
        .hit_mask     (hit_mask2),
        .collision    (collision2),
        .hit_count    (hit_count2)
    );

    typedef enum {Q_X, Q_Y, Q_BUSY, Q_BUSYLEN, Q_MASK, Q_COLL, Q_CNT, Q_X2, Q_Y2, Q_XLT} qsel_t;

    typedef struct {
        string name;
        qsel_t q;
        int    idx;
        int    exp;
        bit    last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   sample_req = 1'b0;
    int   busy_len = 0;
    logic prev_busy = 1'b0;

    function automatic int actual(qsel_t q, int idx);
        case (q)
            Q_X:       return int'(obst_x[idx*CW +: CW]);
            Q_Y:       return int'(obst_y[idx*CW +: CW]);
            Q_BUSY:    return int'(busy);
            Q_BUSYLEN: return busy_len;
            Q_MASK:    return int'(hit_mask);
            Q_COLL:    return int'(collision);
            Q_CNT:     return int'(hit_count);
            Q_X2:      return int'(obst_x2[idx*CW +: CW]);
            Q_Y2:      return int'(obst_y2[idx*CW +: CW]);
            Q_XLT:     return (int'(obst_x[idx*CW +: CW]) < 640) ? 1 : 0;
            default:   return -1;
        endcase
    endfunction

    task automatic expect_val(input string name, input qsel_t q, input int idx, input int exp);
        exp_t e;
        e.name = name;
        e.q    = q;
        e.idx  = idx;
        e.exp  = exp;
        e.last = 1'b0;
        sb.push_back(e);
    endtask

    task automatic end_group();
        sb[sb.size()-1].last = 1'b1;
    endtask

    task automatic checkOutput(input exp_t e);
        int a;
        a = actual(e.q, e.idx);
        checks++;
        if (a != e.exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", e.name, a, e.exp);
        end
    endtask

    // Monitor: a group of expectations is consumed when the sweep ends or on a sample request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_pix);
            if (busy && !prev_busy) busy_len = 0;
            if (busy) busy_len++;
            if ((prev_busy && !busy) || sample_req) begin
                while (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput(e);
                    if (e.last) break;
                end
            end
            prev_busy = busy;
        end
    end

    task automatic applyStimulus(input logic [N-1:0] draw, input logic ship, input logic de_v);
        @(posedge clk_pix);
        #1;
        obst_drawing = draw;
        ship_drawing = ship;
        de           = de_v;
        @(posedge clk_pix);
        #1;
        obst_drawing = '0;
        ship_drawing = 1'b0;
        de           = 1'b0;
    endtask

    task automatic pulse_frame(input logic [N-1:0] draw);
        @(posedge clk_pix);
        #1;
        frame        = 1'b1;
        obst_drawing = draw;
        ship_drawing = |draw;
        de           = |draw;
        @(posedge clk_pix);
        #1;
        frame        = 1'b0;
        obst_drawing = '0;
        ship_drawing = 1'b0;
        de           = 1'b0;
        repeat (13) @(posedge clk_pix);
    endtask

    task automatic sample_now();
        @(posedge clk_pix);
        #1;
        sample_req = 1'b1;
        @(negedge clk_pix);
        #1;
        sample_req = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        en           = 1'b1;
        frame        = 1'b0;
        de           = 1'b0;
        ship_drawing = 1'b0;
        obst_drawing = '0;
        repeat (3) @(posedge clk_pix);
        #1 reset_n = 1'b1;

        expect_val("reset_x3", Q_X, 3, 150);
        expect_val("reset_y3", Q_Y, 3, 90);
        expect_val("reset_busy", Q_BUSY, 0, 0);
        expect_val("reset_mask", Q_MASK, 0, 0);
        expect_val("reset_coll", Q_COLL, 0, 0);
        expect_val("reset_cnt", Q_CNT, 0, 0);
        end_group();
        sample_now();

        expect_val("f1_busy_len", Q_BUSYLEN, 0, 10);
        expect_val("f1_x0", Q_X, 0, 1);
        expect_val("f1_y0", Q_Y, 0, 3);
        expect_val("f1_y9", Q_Y, 9, 273);
        expect_val("f1_x9", Q_X, 9, 451);
        expect_val("wrap_x0", Q_X2, 0, 5);
        expect_val("wrap_x1", Q_X2, 1, 3);
        expect_val("wrap_y1", Q_Y2, 1, 3);
        end_group();
        pulse_frame('0);

        applyStimulus(10'h004, 1'b1, 1'b1);
        expect_val("f2_mask", Q_MASK, 0, 4);
        expect_val("f2_coll", Q_COLL, 0, 1);
        expect_val("f2_cnt", Q_CNT, 0, 1);
        expect_val("f2_y0", Q_Y, 0, 6);
        end_group();
        pulse_frame('0);

        applyStimulus(10'h024, 1'b1, 1'b1);
        expect_val("f3_mask", Q_MASK, 0, 36);
        expect_val("f3_cnt_hold", Q_CNT, 0, 1);
        end_group();
        pulse_frame('0);

        expect_val("f4_mask_clean", Q_MASK, 0, 0);
        expect_val("f4_coll_clean", Q_COLL, 0, 0);
        expect_val("f4_cnt", Q_CNT, 0, 1);
        end_group();
        pulse_frame('0);

        applyStimulus(10'h080, 1'b0, 1'b1);
        applyStimulus(10'h008, 1'b1, 1'b0);
        applyStimulus(10'h001, 1'b1, 1'b1);
        expect_val("f5_mask", Q_MASK, 0, 513);
        expect_val("f5_coll", Q_COLL, 0, 1);
        expect_val("f5_cnt", Q_CNT, 0, 2);
        expect_val("f5_x0", Q_X, 0, 5);
        expect_val("f5_y0", Q_Y, 0, 15);
        end_group();
        pulse_frame(10'h200);

        // en drops right after the sweep starts; the sweep must still finish.
        expect_val("f6_busy_len", Q_BUSYLEN, 0, 10);
        expect_val("f6_y0", Q_Y, 0, 18);
        expect_val("f6_y9", Q_Y, 9, 288);
        expect_val("f6_coll", Q_COLL, 0, 0);
        end_group();
        @(posedge clk_pix);
        #1 frame = 1'b1;
        @(posedge clk_pix);
        #1;
        frame = 1'b0;
        en    = 1'b0;
        repeat (13) @(posedge clk_pix);

        applyStimulus(10'h008, 1'b1, 1'b1);
        pulse_frame(10'h010);
        expect_val("dis_busy", Q_BUSY, 0, 0);
        expect_val("dis_mask", Q_MASK, 0, 0);
        expect_val("dis_cnt", Q_CNT, 0, 2);
        expect_val("dis_y0", Q_Y, 0, 18);
        expect_val("dis_x9", Q_X, 9, 456);
        end_group();
        sample_now();
        en = 1'b1;

        for (int f = 7; f <= 68; f++) pulse_frame('0);

        expect_val("f69_y9", Q_Y, 9, 477);
        expect_val("f69_x9", Q_X, 9, 519);
        end_group();
        pulse_frame('0);

        expect_val("respawn_y9", Q_Y, 9, 0);
`ifdef OBSTACLE_FIELD_RAND_RESPAWN_EN
        expect_val("respawn_x9_range", Q_XLT, 9, 1);
`else
        expect_val("respawn_x9", Q_X, 9, 450);
`endif
        expect_val("f70_x0", Q_X, 0, 70);
        expect_val("f70_y0", Q_Y, 0, 210);
        expect_val("f70_y8", Q_Y, 8, 450);
        end_group();
        pulse_frame('0);

        // Reset lands four cycles into a sweep.
        expect_val("mrst_busy", Q_BUSY, 0, 0);
        expect_val("mrst_x0", Q_X, 0, 0);
        expect_val("mrst_x3", Q_X, 3, 150);
        expect_val("mrst_y9", Q_Y, 9, 270);
        expect_val("mrst_cnt", Q_CNT, 0, 0);
        end_group();
        @(posedge clk_pix);
        #1 frame = 1'b1;
        @(posedge clk_pix);
        #1 frame = 1'b0;
        repeat (3) @(posedge clk_pix);
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk_pix);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk_pix);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL queue_drain: got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
